// File: rtl/argmax_feeder_if.sv
// Output-buffer read port and four-lane argmax comparator bus.
// master = feeder side, slave = buffer/comparator side.
interface argmax_feeder_if #(
  parameter int ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              cmp_reset;
  logic              cmp_enable;
  logic              cmp_trig;
  logic [15:0]       cmp_in1;
  logic [15:0]       cmp_in2;
  logic [15:0]       cmp_in3;
  logic [15:0]       cmp_in4;
  logic [7:0]        cmp_index;

  modport master (
    output rd_en, rd_addr,
    output cmp_reset, cmp_enable, cmp_trig,
    output cmp_in1, cmp_in2, cmp_in3, cmp_in4,
    input  rd_data, cmp_index
  );

  modport slave (
    input  rd_en, rd_addr,
    input  cmp_reset, cmp_enable, cmp_trig,
    input  cmp_in1, cmp_in2, cmp_in3, cmp_in4,
    output rd_data, cmp_index
  );
endinterface

// File: rtl/argmax_feeder.sv
// Sequencer feeding score groups of four to the argmax comparator.
// ARGMAX_FEEDER_PAD_EN: pad a short last group with 16'h8000 lanes.
module argmax_feeder #(
  parameter int NUM_CLASSES = 10,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  argmax_feeder_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result_index
);

  localparam int G = (NUM_CLASSES + 3) / 4;
  localparam logic [7:0] G_LAST = 8'(G - 1);

  if (NUM_CLASSES < 1 || NUM_CLASSES > 252) begin : g_rng_chk
    $error("argmax_feeder: NUM_CLASSES out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_CAPT,
    S_TRIG, S_HOLD, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        g_q, g_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       lane_q [4];
  logic [15:0]       lane_d [4];
  logic              cmp_reset_q, cmp_reset_d;
  logic [7:0]        res_q, res_d;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              cmp_trig;
  logic [1:0]        cap_lane;
  logic              cap_en;
  logic              rd_real;
  logic              cap_real;

  assign cap_lane = (state_q == S_CAPT) ? 2'd3 : k_q - 2'd1;
  assign cap_en   = (state_q == S_CAPT) ||
                    (state_q == S_FETCH && k_q != 2'd0);

`ifdef ARGMAX_FEEDER_PAD_EN
  assign rd_real  = {2'b00, g_q, k_q} < 12'(NUM_CLASSES);
  assign cap_real = {2'b00, g_q, cap_lane} < 12'(NUM_CLASSES);
`else
  if ((NUM_CLASSES % 4) != 0) begin : g_nc_chk
    $error("argmax_feeder: NUM_CLASSES must be a multiple of 4");
  end
  assign rd_real  = 1'b1;
  assign cap_real = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    k_d      = k_q;
    base_d   = base_q;
    lane_d   = lane_q;
    res_d    = res_q;
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    cmp_trig = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          g_d     = '0;
          k_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_en   = rd_real;
        rd_addr = base_q + ADDR_W'({g_q, k_q});
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_CAPT;
      end
      S_CAPT: state_d = S_TRIG;
      S_TRIG: begin
        cmp_trig = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (g_q == G_LAST) begin
          state_d = S_FIN;
        end else begin
          g_d     = g_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        res_d   = bus.cmp_index;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // read data arrives one cycle late, so capture trails issue by a lane
    if (cap_en)
      lane_d[cap_lane] = cap_real ? bus.rd_data : 16'h8000;
    cmp_reset_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      lane_q      <= '{default: 16'h8000};
      cmp_reset_q <= 1'b1;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      k_q         <= k_d;
      base_q      <= base_d;
      lane_q      <= lane_d;
      cmp_reset_q <= cmp_reset_d;
      res_q       <= res_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign result_index   = res_q;
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_addr;
  assign bus.cmp_reset  = cmp_reset_q;
  assign bus.cmp_enable = (state_q != S_IDLE) &&
                          (state_q != S_CLEAR);
  assign bus.cmp_trig   = cmp_trig;
  assign bus.cmp_in1    = lane_q[0];
  assign bus.cmp_in2    = lane_q[1];
  assign bus.cmp_in3    = lane_q[2];
  assign bus.cmp_in4    = lane_q[3];

endmodule

// File: doc/argmax_feeder.md
# argmax_feeder

Sequencer that drives the four-lane argmax comparator in the NPU output stage. After `start`, it reads `NUM_CLASSES` signed 16-bit scores from the output buffer and groups them into sets of four. For each set it issues one comparator trigger with all four lanes held stable across the comparator's delayed sample cycle. When every set is done, it latches the comparator's winning index and pulses `done` toward the host-facing register block.

## Interface
- `NUM_CLASSES`, default 10: number of scores to scan; 1..252.
- `ADDR_W`, default 8: output-buffer address width.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a scan; ignored while `busy`=1.
- `base_addr` in ADDR_W: buffer address of score 0; sampled on accepted `start`.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_W: buffer read address.
- `rd_data` in 16: buffer read data, valid exactly 1 cycle after `rd_en`.
- `cmp_reset` out 1: synchronous reset to the comparator; registered.
- `cmp_enable` out 1: comparator enable.
- `cmp_trig` out 1: comparator trigger pulse.
- `cmp_in1`..`cmp_in4` out 16 each: lane data, signed two's complement; lane k carries score 4g+k-1 for group g.
- `cmp_index` in 8: comparator winner index; 1-based, 0 = none.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when `result_index` updates.
- `result_index` out 8: latched winner; holds until next `done`.

## Operation
- G = ceil(NUM_CLASSES/4) groups. Lanes with index >= NUM_CLASSES are padding lanes.
- FSM states: IDLE, CLEAR, FETCH, CAPT, TRIG, HOLD, FIN.
- IDLE: `busy`=0. An accepted `start` latches `base_addr` and sets group counter g=0 -> CLEAR.
- CLEAR (1 cycle): `cmp_reset`=1, `cmp_enable`=0 -> FETCH.
- FETCH (4 cycles, lane counter k=0..3): for real lanes, `rd_en`=1 and `rd_addr`=base+4g+k (wraps mod 2^ADDR_W). Padding lanes: `rd_en`=0 and the lane register is loaded with 16'h8000. Each read's `rd_data` is captured into lane k-1 on the next cycle. After k=3 -> CAPT.
- CAPT (1 cycle): capture lane 4 data (or padding) -> TRIG.
- TRIG (1 cycle): `cmp_trig`=1 -> HOLD.
- HOLD (1 cycle): `cmp_trig`=0, lanes unchanged; the comparator samples the lanes at the end of this cycle. If g=G-1 -> FIN; else g+1 -> FETCH.
- FIN (1 cycle): `result_index` <= `cmp_index`, `done`=1 -> IDLE.
- `cmp_enable`=1 in all states except IDLE and CLEAR. Lane registers change only in FETCH and CAPT.
- Ties within a group resolve to the lowest lane. Ties across groups keep the earlier winner, because the comparator replaces only on strict greater-than.
- A score of exactly 16'h8000 never wins. If all scores are 16'h8000, `result_index`=0.
- `start` during `busy`: dropped, with no queuing.

## Timing
- Reset (reset_n low, asynchronous): state IDLE; `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `cmp_trig`=0, `cmp_enable`=0; `cmp_reset`=1, released to 0 on the first clock after deassertion; lanes=16'h8000; `result_index`=0.
- Reset mid-scan: the scan is abandoned with no `done`; the comparator is cleared via `cmp_reset`.
- Latency from `start` cycle to `done` cycle: 1 + 1 + 7·G cycles (NUM_CLASSES=10 -> 23).
- `busy` rises the cycle after `start` and falls the cycle after `done`. A new `start` is accepted in the first IDLE cycle after the previous scan.
- `cmp_trig` is high exactly one cycle per group, G pulses per scan, spaced 7 cycles apart.

## Configuration
- `ARGMAX_FEEDER_PAD_EN` defined: padding lanes are forced to 16'h8000 without a buffer read. Any NUM_CLASSES in 1..252 is legal.
- Not defined: no padding logic. NUM_CLASSES must be a multiple of 4, and elaboration fails via `$error` otherwise. All 4·G reads are issued.

## Test plan
- Scores 0..9 = {5,-3,7,2,7,0,1,-8,6,4}, base=0x10 -> `rd_addr` 0x10..0x19 (padding lanes unread), `result_index`=3, `done` on cycle 23.
- All ten scores = 16'h8000 -> `result_index`=0; exactly 3 `cmp_trig` pulses.
- base=0xFC, NUM_CLASSES=8, score 5 = 0x7FFF, others 0 -> reads wrap 0xFC..0x03; `result_index`=6.
- `start` asserted again at cycle 5 of a scan -> ignored; single `done`; second `start` after `done` yields the same result.
- reset_n pulsed low during third FETCH -> outputs take reset values immediately; `cmp_reset`=1; no `done`; a fresh scan is correct.
- Lane values held between TRIG and HOLD: bench asserts `cmp_in1..4` are identical in both cycles for every group.
